// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous input; both stages reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so the second stage takes the first stage's pre-edge value.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with start-glitch rejection, framing check and break hold-off.
// Optional even parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_rx,
    input  logic                 baud_x16,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    logic                 w_rxd;

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [TICK_W-1:0]    w_tick_nxt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] r_d_out;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 w_load;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;
    logic                 w_mid_strobe;
    logic                 w_last_strobe;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 w_par_nxt;
    logic                 r_parity_err;
    logic                 w_perr_nxt;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rxd),
        .o_q   (w_rxd)
    );

    assign w_mid_strobe  = baud_x16 && (r_tick_cnt == TICK_MID);
    assign w_last_strobe = baud_x16 && (r_tick_cnt == TICK_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par_bit;
        w_perr_nxt  = 1'b0;
`endif

        if (!enable_rx) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_rxd) begin
                        w_state_nxt = START;
                        w_tick_nxt  = '0;
                    end
                end

                START: begin
                    if (w_mid_strobe) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = w_rxd ? IDLE : DATA;
                    end else if (baud_x16) begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end

                DATA: begin
                    if (w_last_strobe) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {w_rxd, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt   = r_bit_cnt + BIT_ONE;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end
                    end else if (baud_x16) begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_last_strobe) begin
                        w_tick_nxt  = '0;
                        w_par_nxt   = w_rxd;
                        w_state_nxt = STOP;
                    end else if (baud_x16) begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end
`endif

                STOP: begin
                    if (w_last_strobe) begin
                        w_tick_nxt = '0;
                        if (w_rxd) begin
                            w_load      = 1'b1;
                            w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data ones plus parity bit must sum to even.
                            w_perr_nxt  = (^r_shift) ^ r_par_bit;
`endif
                            w_state_nxt = IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = BREAK;
                        end
                    end else if (baud_x16) begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end

                BREAK: begin
                    if (baud_x16 && w_rxd) begin
                        w_state_nxt = IDLE;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_d_out     <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
            if (w_load) begin
                r_d_out <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bit    <= w_par_nxt;
            r_parity_err <= w_perr_nxt;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // BREAK is not a reception in progress: busy drops together with the frame_err pulse.
    assign rx_busy   = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
    assign d_out     = r_d_out;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences, random frames.
module tb_uart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int BAUD_DIV   = 4;
    localparam int BIT_CLK    = OVERSAMPLE * BAUD_DIV;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       bad_par;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_dout;
    } vec_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable_rx = 1'b0;
    logic       baud_x16  = 1'b0;
    logic       rxd       = 1'b1;
    logic [7:0] d_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    int         checks       = 0;
    int         errors       = 0;
    int         n_valid      = 0;
    int         n_ferr       = 0;
    int         n_perr       = 0;
    int         n_perr_alone = 0;
    int         div_cnt      = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[8];

    uart_rx #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_rx  (enable_rx),
        .baud_x16   (baud_x16),
        .rxd        (rxd),
        .d_out      (d_out),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div_cnt  = (div_cnt + 1) % BAUD_DIV;
        baud_x16 = (div_cnt == 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_valid++;
                got_q.push_back(d_out);
            end
            if (frame_err) n_ferr++;
            if (parity_err) begin
                n_perr++;
                if (!rx_valid) n_perr_alone++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Leaves rxd at the stop-bit level; the caller decides what follows.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i]);
        if (PAR) drive_bit((^data) ^ bad_par);
        drive_bit(stop_bit);
    endtask

    task automatic idle_clks(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int         v0;
        int         f0;
        int         p0;
        logic [7:0] held;
        logic [7:0] rnd;
        logic       good;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[2] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07};
        vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, PAR,  8'h07};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80};
        vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[7] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01};

        enable_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset d_out", d_out, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_busy", rx_busy, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset parity_err", parity_err, 1'b0);
        rst_n = 1'b1;
        idle_clks(BIT_CLK);

        for (int i = 0; i < 8; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            p0 = n_perr;
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].bad_par);
            idle_clks(BIT_CLK);
            check($sformatf("vec%0d rx_valid count", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d frame_err count", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d parity_err count", i), n_perr - p0, vecs[i].exp_perr);
            check($sformatf("vec%0d d_out", i), d_out, vecs[i].exp_dout);
            check($sformatf("vec%0d rx_busy idle", i), rx_busy, 1'b0);
        end

        // Back-to-back frames with no idle gap.
        got_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_clks(BIT_CLK);
        check("b2b frame count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("b2b first byte", got_q[0], 8'h00);
            check("b2b second byte", got_q[1], 8'hFF);
        end

        // Short low glitch: start is accepted, then rejected at mid-bit.
        v0   = n_valid;
        f0   = n_ferr;
        held = d_out;
        rxd  = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch rx_busy during start", rx_busy, 1'b1);
        repeat (3 * BAUD_DIV - 8) @(negedge clk);
        idle_clks(2 * BIT_CLK);
        check("glitch rx_valid count", n_valid - v0, 0);
        check("glitch frame_err count", n_ferr - f0, 0);
        check("glitch d_out held", d_out, held);
        check("glitch rx_busy", rx_busy, 1'b0);

        // Bad stop bit followed by a line held low: one frame_err, no retrigger.
        v0   = n_valid;
        f0   = n_ferr;
        held = d_out;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (5 * BIT_CLK) @(negedge clk);
        check("break frame_err count", n_ferr - f0, 1);
        check("break rx_valid count", n_valid - v0, 0);
        check("break d_out held", d_out, held);
        idle_clks(BIT_CLK);
        send_frame(8'h42, 1'b1, 1'b0);
        idle_clks(BIT_CLK);
        check("after break rx_valid count", n_valid - v0, 1);
        check("after break d_out", d_out, 8'h42);

        // Receive disabled mid-frame: aborts, no pulses, d_out retained.
        v0   = n_valid;
        f0   = n_ferr;
        held = d_out;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        enable_rx = 1'b0;
        repeat (2) @(negedge clk);
        check("disable rx_busy", rx_busy, 1'b0);
        for (int i = 3; i < DATA_BITS; i++) drive_bit(1'b0);
        if (PAR) drive_bit(1'b0);
        drive_bit(1'b0);
        idle_clks(BIT_CLK);
        enable_rx = 1'b1;
        idle_clks(BIT_CLK);
        check("disable rx_valid count", n_valid - v0, 0);
        check("disable frame_err count", n_ferr - f0, 0);
        check("disable d_out held", d_out, held);

        // Reset asserted during bit 4 of 0x5A, then a clean 0x5A.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rnd_bit(8'h5A, i));
        rxd = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        check("pre-reset rx_busy", rx_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset d_out", d_out, 8'h00);
        check("mid-reset rx_busy", rx_busy, 1'b0);
        check("mid-reset rx_valid", rx_valid, 1'b0);
        check("mid-reset frame_err", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_clks(BIT_CLK);
        v0 = n_valid;
        send_frame(8'h5A, 1'b1, 1'b0);
        idle_clks(BIT_CLK);
        check("post-reset rx_valid count", n_valid - v0, 1);
        check("post-reset d_out", d_out, 8'h5A);

        // Random frames against a queue model: good stop bits deliver their byte in order.
        got_q.delete();
        exp_q.delete();
        f0 = n_ferr;
        v0 = 0;
        for (int i = 0; i < 24; i++) begin
            rnd  = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            send_frame(rnd, good, 1'b0);
            if (good) begin
                exp_q.push_back(rnd);
                idle_clks($urandom_range(0, 40));
            end else begin
                v0++;
                idle_clks(8 + $urandom_range(0, 40));
            end
        end
        idle_clks(BIT_CLK);
        check("random frame count", got_q.size(), exp_q.size());
        check("random frame_err count", n_ferr - f0, v0);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("random byte %0d", i), got_q[i], exp_q[i]);
        end

        check("parity_err without rx_valid", n_perr_alone, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic rnd_bit(input logic [7:0] v, input int idx);
        return v[idx];
    endfunction

endmodule
